alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Command-driven control unit for the 8-bit accumulator ALU (add/ashl/xnor/div2/load/pass-AC/complement).
//  Owns the AC and E registers and fetches the DR operand from memory over a variable-latency read port.
//  Drives the ALU selector lines, writes the result back to AC/E, and executes STORE through the ALU pass-AC path.
//  Sits between the instruction decoder (cmd_* side) and the data memory and ALU.
// PARAMETERS
//  ADDR_W   8   memory address width
//  TIMEOUT  16  max cycles spent in WAIT for mem_rvalid before aborting with err (>=1)
// PORTS
//  clk         in   1       clock; all state changes on the rising edge
//  reset       in   1       asynchronous, active-high reset
//  cmd_valid   in   1       command present
//  cmd_ready   out  1       high only in IDLE; accept = cmd_valid & cmd_ready
//  cmd_op      in   3       000 ADD, 001 ASHL, 010 XNOR, 011 DIV2, 100 LOAD, 101 STORE, 110 CMPL, 111 CLE
//  cmd_addr    in   ADDR_W  operand/store address
//  mem_rd      out  1       one-cycle read strobe
//  mem_wr      out  1       one-cycle write strobe
//  mem_addr    out  ADDR_W  latched cmd_addr; valid while mem_rd or mem_wr is high
//  mem_wdata   out  8       alu_result during the STORE write cycle
//  mem_rdata   in   8       read data, sampled when mem_rvalid is high in WAIT
//  mem_rvalid  in   1       read response, earliest 1 cycle after mem_rd
//  alu_ac      out  8       = ac register
//  alu_dr      out  8       = internal dr register
//  alu_sel     out  3       ALU selector
//  alu_result  in   8       ALU result
//  alu_e       in   1       ALU carry/shift-out
//  ac          out  8       accumulator
//  e           out  1       E flag
//  done        out  1       one-cycle pulse when a command completes
//  err         out  1       qualifies done; high only on timeout abort
//  busy        out  1       = ~cmd_ready
// BEHAVIOUR
//  Reset values: state=IDLE, ac=0, e=0, dr=0, mem_rd=mem_wr=done=err=0, alu_sel=101, mem_addr=0, timeout cnt=0.
//  Reset is asynchronous; it aborts any command immediately (strobes drop, AC/E cleared).
//  States: IDLE, FETCH, WAIT, EXEC, WRITE, DONE.
//  IDLE: on accept, latch op and addr.
//   ops 000/001/010/011/100/110 -> FETCH; op 101 -> WRITE; op 111 -> EXEC.
//  FETCH: mem_rd=1 (1 cycle); cnt<=0; -> WAIT.
//  WAIT: if mem_rvalid: dr<=mem_rdata, -> EXEC.
//   else cnt++; when cnt==TIMEOUT-1 with no rvalid -> DONE with err=1; ac, e and dr are unchanged.
//  EXEC: alu_sel=op (111 drives 101). At end of cycle:
//   ops 000-110 except 101: ac<=alu_result.
//   ops 000/001/011: e<=alu_e. Ops 010/100/110: e unchanged. Op 111: e<=0, ac unchanged.
//   -> DONE.
//  WRITE: alu_sel=101, mem_wr=1, mem_wdata=alu_result (==ac); ac/e unchanged; -> DONE.
//  DONE: done=1 (err as set); -> IDLE. cmd_ready=0 in DONE.
//   A held cmd_valid is accepted in the following IDLE cycle.
//  alu_sel=101 in all states other than EXEC/WRITE.
//  Latency, accept edge to done cycle (L = read latency in cycles after mem_rd):
//   read ops: 3+L cycles.
//   STORE and CLE: 2 cycles.
//   timeout: 2+TIMEOUT cycles.
//  mem_rvalid outside WAIT is ignored, including a late response after timeout or reset.
//  All arithmetic is 8-bit; the carry lives only in e. cmd_* is ignored while busy.
// TESTING
//  1 Reset asserted mid-WAIT -> next edge: IDLE, cmd_ready=1, ac=0, e=0, mem_rd=0; later mem_rvalid ignored.
//  2 LOAD mem[10]=C1, then ADD mem[11]=A3 (L=1)
//    -> ac=64, e=1; done 4 cycles after each accept; ADD 31+C4 -> ac=F5, e=0.
//  3 LOAD B1; ASHL mem=B1 -> ac=62, e=1; DIV2 mem=46 -> ac=23, e=0.
//    XNOR ac=B2, mem=86 -> ac=CB, e unchanged.
//    CMPL mem=9A -> ac=66.
//  4 ac=9A, STORE addr 20 -> exactly 1 cycle mem_wr=1, mem_addr=20, mem_wdata=9A; mem_rd never set.
//    done after 2 cycles; ac unchanged.
//    CLE with e=1 -> e=0.
//  5 Read with no mem_rvalid -> done=1, err=1 at 2+TIMEOUT cycles; ac/e unchanged.
//    A response arriving later is ignored.
//  6 cmd_valid held high for ADD, ADD -> second accept occurs the cycle after done.
//    No strobe overlap; L=5 is handled with no timeout.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: command-driven control unit for the 8-bit accumulator ALU.
// Owns AC, E and DR, fetches the DR operand over a variable-latency read
// port, steers the external ALU and writes results back to AC/E or memory.
module alu_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_rvalid,
  output logic [7:0]        alu_ac,
  output logic [7:0]        alu_dr,
  output logic [2:0]        alu_sel,
  input  logic [7:0]        alu_result,
  input  logic              alu_e,
  output logic [7:0]        ac,
  output logic              e,
  output logic              done,
  output logic              err,
  output logic              busy
);

  // The WAIT counter only ever holds 0 .. TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_ASHL  = 3'b001;
  localparam logic [2:0] OP_DIV2  = 3'b011;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_CLE   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        ac_q, ac_d;
  logic [7:0]        dr_q, dr_d;
  logic              e_q, e_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 3'b000;
      addr_q  <= '0;
      ac_q    <= 8'h00;
      dr_q    <= 8'h00;
      e_q     <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      ac_q    <= ac_d;
      dr_q    <= dr_d;
      e_q     <= e_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, register updates and strobes for each phase of a command.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    ac_d      = ac_q;
    dr_d      = dr_q;
    e_d       = e_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    cmd_ready = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = 8'h00;
    alu_sel   = OP_STORE;
    done      = 1'b0;
    err       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d   = cmd_op;
          addr_d = cmd_addr;
          err_d  = 1'b0;
          if (cmd_op == OP_STORE) begin
            state_d = S_WRITE;
          end else if (cmd_op == OP_CLE) begin
            state_d = S_EXEC;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        mem_rd  = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          dr_d    = mem_rdata;
          state_d = S_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXEC: begin
        alu_sel = (op_q == OP_CLE) ? OP_STORE : op_q;
        if (op_q == OP_CLE) begin
          e_d = 1'b0;
        end else begin
          ac_d = alu_result;
          if (op_q == OP_ADD || op_q == OP_ASHL || op_q == OP_DIV2) begin
            e_d = alu_e;
          end
        end
        state_d = S_DONE;
      end
      S_WRITE: begin
        alu_sel   = OP_STORE;
        mem_wr    = 1'b1;
        mem_wdata = alu_result;
        state_d   = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_addr = addr_q;
  assign alu_ac   = ac_q;
  assign alu_dr   = dr_q;
  assign ac       = ac_q;
  assign e        = e_q;
  assign busy     = ~cmd_ready;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: drives alu_sequencer with directed and random commands,
// emulating the data memory and ALU, and compares against a command-level
// reference model of AC, E, DR and memory.
module tb_alu_sequencer;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_addr;
  logic       mem_rd;
  logic       mem_wr;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_rvalid;
  logic [7:0] alu_ac;
  logic [7:0] alu_dr;
  logic [2:0] alu_sel;
  logic [7:0] alu_result;
  logic       alu_e;
  logic [7:0] ac;
  logic       e;
  logic       done;
  logic       err;
  logic       busy;

  int passCount  = 0;
  int checkCount = 0;

  logic [7:0] mem [256];
  logic [7:0] expAc;
  logic       expE;
  logic [7:0] expDr;

  alu_sequencer #(.ADDR_W(8), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .alu_ac     (alu_ac),
    .alu_dr     (alu_dr),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_e      (alu_e),
    .ac         (ac),
    .e          (e),
    .done       (done),
    .err        (err),
    .busy       (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Stand-in for the external accumulator ALU.
  always_comb begin
    alu_result = alu_ac;
    alu_e      = 1'b0;
    case (alu_sel)
      3'b000: {alu_e, alu_result} = {1'b0, alu_ac} + {1'b0, alu_dr};
      3'b001: {alu_e, alu_result} = {alu_dr, 1'b0};
      3'b010: alu_result = ~(alu_ac ^ alu_dr);
      3'b011: {alu_result, alu_e} = {1'b0, alu_dr};
      3'b100: alu_result = alu_dr;
      3'b110: alu_result = ~alu_dr + 8'd1;
      default: alu_result = alu_ac;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Command-level reference: what one finished command does to AC/E/DR/memory.
  task automatic modelCmd(input logic [2:0] op, input logic [7:0] addr, input int lat);
    logic [7:0] d;
    int sum;
    if (op == 3'd5) begin
      mem[addr] = expAc;
    end else if (op == 3'd7) begin
      expE = 1'b0;
    end else if (lat > 0) begin
      d = mem[addr];
      expDr = d;
      case (op)
        3'd0: begin
          sum   = int'(expAc) + int'(d);
          expAc = sum[7:0];
          expE  = (sum > 255);
        end
        3'd1: begin
          expAc = 8'((int'(d) * 2) % 256);
          expE  = (d >= 8'h80);
        end
        3'd2: expAc = ~(expAc ^ d);
        3'd3: begin
          expAc = d / 2;
          expE  = (d % 2) == 1;
        end
        3'd4: expAc = d;
        default: expAc = 8'((256 - int'(d)) % 256);
      endcase
    end
  endtask

  // Issue one command and play memory; lat 0 means the read never answers.
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] addr, input int lat, input bit hold);
    int idx, rdIdx, rdCnt, wrCnt, overlap, doneIdx, expLat;
    bit seen, isRead, expErr, obsErr, obsReady;
    logic [7:0] wrAddr, wrData, rdAddr;
    isRead  = (op != 3'd5) && (op != 3'd7);
    expErr  = isRead && (lat == 0);
    expLat  = !isRead ? 2 : (lat == 0 ? 2 + TIMEOUT : 3 + lat);
    rdIdx   = -100; rdCnt = 0; wrCnt = 0; overlap = 0; doneIdx = -1;
    seen    = 1'b0; obsErr = 1'b0; obsReady = 1'b1;
    wrAddr  = 8'h00; wrData = 8'h00; rdAddr = 8'h00;

    @(negedge clk);
    checkOutput("cmd_ready_at_issue", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    @(negedge clk);
    idx       = 1;
    cmd_valid = hold;
    cmd_op    = 3'($urandom);
    cmd_addr  = 8'($urandom);
    while (!seen && idx < 60) begin
      mem_rvalid = 1'b0;
      mem_rdata  = 8'($urandom);
      if (mem_rd) begin
        rdCnt++;
        rdIdx  = idx;
        rdAddr = mem_addr;
        mem_rvalid = 1'b1;
      end
      if (mem_wr) begin
        wrCnt++;
        wrAddr = mem_addr;
        wrData = mem_wdata;
      end
      if (mem_rd && mem_wr) overlap++;
      if (lat > 0 && idx == rdIdx + lat) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem[addr];
      end
      if (done) begin
        seen     = 1'b1;
        doneIdx  = idx;
        obsErr   = err;
        obsReady = cmd_ready;
      end else begin
        @(negedge clk);
        idx++;
      end
    end
    mem_rvalid = 1'b0;

    modelCmd(op, addr, lat);
    checkOutput("done_seen", seen, 1);
    checkOutput("done_latency", doneIdx, expLat);
    checkOutput("err", obsErr, expErr);
    checkOutput("ready_in_done", obsReady, 0);
    checkOutput("ac", ac, expAc);
    checkOutput("e", e, expE);
    checkOutput("dr", alu_dr, expDr);
    checkOutput("rd_count", rdCnt, isRead ? 1 : 0);
    checkOutput("wr_count", wrCnt, (op == 3'd5) ? 1 : 0);
    checkOutput("strobe_overlap", overlap, 0);
    if (isRead) checkOutput("rd_addr", rdAddr, addr);
    if (op == 3'd5) begin
      checkOutput("wr_addr", wrAddr, addr);
      checkOutput("wr_data", wrData, mem[addr]);
    end
  endtask

  initial begin
    int r, lat;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    expAc = 8'h00; expE = 1'b0; expDr = 8'h00;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_addr = 8'h00;
    mem_rvalid = 1'b0; mem_rdata = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", cmd_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ac", ac, 8'h00);
    checkOutput("rst_e", e, 0);
    checkOutput("rst_dr", alu_dr, 8'h00);
    checkOutput("rst_strobes", {mem_rd, mem_wr, done, err}, 4'b0000);
    checkOutput("rst_sel", alu_sel, 3'b101);
    checkOutput("rst_addr", mem_addr, 8'h00);
    reset = 1'b0;

    // LOAD then ADD with carry out, then ADD without carry
    mem[10] = 8'hC1; mem[11] = 8'hA3; mem[12] = 8'h31; mem[13] = 8'hC4;
    applyStimulus(3'd4, 8'd10, 1, 1'b0);
    applyStimulus(3'd0, 8'd11, 1, 1'b0);
    checkOutput("t2_ac_64", ac, 8'h64);
    checkOutput("t2_e_1", e, 1);
    applyStimulus(3'd4, 8'd12, 2, 1'b0);
    applyStimulus(3'd0, 8'd13, 1, 1'b0);
    checkOutput("t2_ac_F5", ac, 8'hF5);
    checkOutput("t2_e_0", e, 0);

    // Shifts, XNOR keeping E, two's complement
    mem[14] = 8'hB1; mem[15] = 8'h46; mem[16] = 8'h80; mem[17] = 8'hB2;
    mem[18] = 8'h86; mem[19] = 8'h9A;
    applyStimulus(3'd4, 8'd14, 1, 1'b0);
    applyStimulus(3'd1, 8'd14, 3, 1'b0);
    checkOutput("t3_ashl_ac", ac, 8'h62);
    checkOutput("t3_ashl_e", e, 1);
    applyStimulus(3'd3, 8'd15, 1, 1'b0);
    checkOutput("t3_div2_ac", ac, 8'h23);
    checkOutput("t3_div2_e", e, 0);
    applyStimulus(3'd1, 8'd16, 1, 1'b0);
    applyStimulus(3'd4, 8'd17, 1, 1'b0);
    applyStimulus(3'd2, 8'd18, 2, 1'b0);
    checkOutput("t3_xnor_ac", ac, 8'hCB);
    checkOutput("t3_xnor_e", e, 1);
    applyStimulus(3'd6, 8'd19, 1, 1'b0);
    checkOutput("t3_cmpl_ac", ac, 8'h66);

    // STORE through the pass-AC path, then CLE
    applyStimulus(3'd4, 8'd19, 1, 1'b0);
    applyStimulus(3'd5, 8'h20, 1, 1'b0);
    checkOutput("t4_store_mem", mem[8'h20], 8'h9A);
    checkOutput("t4_e_before_cle", e, 1);
    applyStimulus(3'd7, 8'h00, 1, 1'b0);
    checkOutput("t4_cle_e", e, 0);

    // Timeout, then a late response that must be ignored
    applyStimulus(3'd0, 8'h30, 0, 1'b0);
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 8'h5A;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checkOutput("t5_late_dr", alu_dr, expDr);
    checkOutput("t5_late_ac", ac, expAc);
    checkOutput("t5_late_ready", cmd_ready, 1);

    // Reset mid-WAIT aborts the read
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_addr = 8'h40;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("t1_busy_in_wait", busy, 1);
    reset = 1'b1;
    #1;
    checkOutput("t1_ready", cmd_ready, 1);
    checkOutput("t1_ac", ac, 8'h00);
    checkOutput("t1_e", e, 0);
    checkOutput("t1_rd", mem_rd, 0);
    @(negedge clk);
    reset = 1'b0; mem_rvalid = 1'b1; mem_rdata = 8'hEE;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checkOutput("t1_late_dr", alu_dr, 8'h00);
    checkOutput("t1_late_ac", ac, 8'h00);
    checkOutput("t1_late_done", done, 0);
    expAc = 8'h00; expE = 1'b0; expDr = 8'h00;

    // Back-to-back ADDs with cmd_valid held, slow memory
    applyStimulus(3'd0, 8'h50, 5, 1'b1);
    applyStimulus(3'd0, 8'h51, 5, 1'b0);

    // Response on the last WAIT cycle still completes
    applyStimulus(3'd4, 8'h52, TIMEOUT, 1'b0);

    // Random commands
    for (int n = 0; n < 30; n++) begin
      r   = $urandom_range(0, 9);
      lat = (r == 0) ? 0 : ((r == 9) ? TIMEOUT : r);
      applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), lat, 1'($urandom_range(0, 1)));
    end
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
